// File: rtl/fp32_to_int.sv
`default_nettype none
// ============================================================================
// Module   : fp32_to_int
// Brief    : Sequential IEEE-754 single-precision to int32 converter with
//            round-to-nearest-even. Optional macro FP2INT_SATURATE_EN
//            enables saturating out-of-range results.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_to_int #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] c_int_min = 32'h8000_0000;
    localparam logic [31:0] c_int_max = 32'h7FFF_FFFF;
    localparam logic [4:0]  c_step    = 5'(SHIFT_STEP);
`ifdef FP2INT_SATURATE_EN
    localparam logic [31:0] c_nan_val = 32'h0000_0000;
`else
    localparam logic [31:0] c_nan_val = c_int_min;
`endif

    function automatic logic [31:0] ovf_value(input logic sign);
`ifdef FP2INT_SATURATE_EN
        ovf_value = sign ? c_int_min : c_int_max;
`else
        ovf_value = c_int_min;
`endif
    endfunction

    state_t      r_state, w_state_nxt;
    logic [57:0] r_acc, w_acc_nxt;
    logic [4:0]  r_rem, w_rem_nxt;
    logic        r_sign, w_sign_nxt;
    logic [31:0] r_result, w_result_nxt;
    logic        r_exc, w_exc_nxt;
    logic        r_ovf, w_ovf_nxt;
    logic        r_unf, w_unf_nxt;

    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic [4:0]  w_step;
    logic        w_guard, w_sticky, w_lsb, w_up;
    logic [32:0] w_mag;
    logic [31:0] w_neg;
    logic        w_round_ovf;

    assign w_s = fp_in[31];
    assign w_e = fp_in[30:23];
    assign w_f = fp_in[22:0];

    assign w_step = (r_rem < c_step) ? r_rem : c_step;

    // Integer field is acc[57:26]; everything below bit 26 is fraction.
    assign w_guard     = r_acc[25];
    assign w_sticky    = |r_acc[24:0];
    assign w_lsb       = r_acc[26];
    assign w_up        = w_guard & (w_sticky | w_lsb);
    assign w_mag       = {1'b0, r_acc[57:26]} + 33'(w_up);
    assign w_neg       = 32'd0 - w_mag[31:0];
    assign w_round_ovf = r_sign ? (w_mag > 33'h0_8000_0000) : (w_mag > 33'h0_7FFF_FFFF);

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_rem_nxt    = r_rem;
        w_sign_nxt   = r_sign;
        w_result_nxt = r_result;
        w_exc_nxt    = r_exc;
        w_ovf_nxt    = r_ovf;
        w_unf_nxt    = r_unf;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_sign_nxt = w_s;
                    if (w_e == 8'hFF) begin
                        w_exc_nxt    = 1'b1;
                        w_ovf_nxt    = (w_f == 23'd0);
                        w_unf_nxt    = 1'b0;
                        w_result_nxt = (w_f != 23'd0) ? c_nan_val : ovf_value(w_s);
                        w_state_nxt  = ST_DONE;
                    end else if (w_e == 8'd0) begin
                        w_exc_nxt    = 1'b0;
                        w_ovf_nxt    = 1'b0;
                        w_unf_nxt    = (w_f != 23'd0);
                        w_result_nxt = 32'd0;
                        w_state_nxt  = ST_DONE;
                    end else if (w_e <= 8'd125) begin
                        w_exc_nxt    = 1'b0;
                        w_ovf_nxt    = 1'b0;
                        w_unf_nxt    = 1'b1;
                        w_result_nxt = 32'd0;
                        w_state_nxt  = ST_DONE;
                    end else if (w_e >= 8'd158) begin
                        w_exc_nxt   = 1'b0;
                        w_unf_nxt   = 1'b0;
                        w_state_nxt = ST_DONE;
                        // -2^31 is the only representable value at E=31.
                        if (w_s && (w_e == 8'd158) && (w_f == 23'd0)) begin
                            w_ovf_nxt    = 1'b0;
                            w_result_nxt = c_int_min;
                        end else begin
                            w_ovf_nxt    = 1'b1;
                            w_result_nxt = ovf_value(w_s);
                        end
                    end else begin
                        w_acc_nxt = {31'd0, 1'b1, w_f, 3'd0};
                        if (w_e == 8'd127) begin
                            w_state_nxt = ST_ROUND;
                        end else if (w_e == 8'd126) begin
                            w_acc_nxt   = {32'd0, 1'b1, w_f, 2'd0};
                            w_state_nxt = ST_ROUND;
                        end else begin
                            w_rem_nxt   = 5'(w_e - 8'd127);
                            w_state_nxt = ST_ALIGN;
                        end
                    end
                end
            end
            ST_ALIGN: begin
                w_acc_nxt = r_acc << w_step;
                w_rem_nxt = r_rem - w_step;
                if (r_rem == w_step) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_exc_nxt   = 1'b0;
                w_state_nxt = ST_DONE;
                if (w_round_ovf) begin
                    w_ovf_nxt    = 1'b1;
                    w_unf_nxt    = 1'b0;
                    w_result_nxt = ovf_value(r_sign);
                end else begin
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = (w_mag == 33'd0);
                    w_result_nxt = r_sign ? w_neg : w_mag[31:0];
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_rem    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_rem    <= w_rem_nxt;
            r_sign   <= w_sign_nxt;
            r_result <= w_result_nxt;
            r_exc    <= w_exc_nxt;
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign Exception = r_exc;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_to_int
// Brief    : Directed self-checking bench for fp32_to_int.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_to_int;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        logic [2:0]  flg;   // {Exception, Overflow, Underflow}
        int          lat;
    } vec_t;

`ifdef FP2INT_SATURATE_EN
    localparam logic [31:0] c_pos_ovf = 32'h7FFF_FFFF;
    localparam logic [31:0] c_nan_res = 32'h0000_0000;
`else
    localparam logic [31:0] c_pos_ovf = 32'h8000_0000;
    localparam logic [31:0] c_nan_res = 32'h8000_0000;
`endif

    fp32_to_int #(.SHIFT_STEP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_in     (fp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand, measures edges from accept (accept edge = 1) to out_valid.
    task automatic convert(input logic [31:0] op, output int lat,
                           output logic [31:0] res, output logic [2:0] flg);
        @(negedge clk);
        fp_in    = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = result;
        flg = {Exception, Overflow, Underflow};
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_hs: in_ready/out_valid got %b want 10", {in_ready, out_valid});
        end
        n_cmp++;
        if ({result, Exception, Overflow, Underflow} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_out: result=%h flags=%b want 0", result, {Exception, Overflow, Underflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rounding();
        vec_t q[$];
        int lat;
        logic [31:0] res;
        logic [2:0] flg;
        q.push_back(vec_t'{32'h3FC0_0000, 32'h0000_0002, 3'b000, 2}); // 1.5 tie up
        q.push_back(vec_t'{32'h4020_0000, 32'h0000_0002, 3'b000, 3}); // 2.5 tie down
        q.push_back(vec_t'{32'hBF40_0000, 32'hFFFF_FFFF, 3'b000, 2}); // -0.75
        q.push_back(vec_t'{32'h4060_0000, 32'h0000_0004, 3'b000, 3}); // 3.5
        q.push_back(vec_t'{32'hC060_0000, 32'hFFFF_FFFC, 3'b000, 3}); // -3.5
        q.push_back(vec_t'{32'h3F80_0000, 32'h0000_0001, 3'b000, 2}); // 1.0
        q.push_back(vec_t'{32'h3FC0_0001, 32'h0000_0002, 3'b000, 2}); // just above 1.5
        q.push_back(vec_t'{32'h3FE0_0000, 32'h0000_0002, 3'b000, 2}); // 1.75
        q.push_back(vec_t'{32'h4B00_0001, 32'h0080_0001, 3'b000, 5}); // 2^23+1
        q.push_back(vec_t'{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 6}); // largest E=30
        foreach (q[i]) begin
            convert(q[i].op, lat, res, flg);
            n_cmp++;
            if (res !== q[i].res) begin
                n_err++;
                $display("FAIL round_res[%h]: got %h want %h", q[i].op, res, q[i].res);
            end
            n_cmp++;
            if (flg !== q[i].flg) begin
                n_err++;
                $display("FAIL round_flg[%h]: got %b want %b", q[i].op, flg, q[i].flg);
            end
            n_cmp++;
            if (lat != q[i].lat) begin
                n_err++;
                $display("FAIL round_lat[%h]: got %0d want %0d", q[i].op, lat, q[i].lat);
            end
        end
    endtask

    task automatic test_special();
        vec_t q[$];
        int lat;
        logic [31:0] res;
        logic [2:0] flg;
        q.push_back(vec_t'{32'hCF00_0000, 32'h8000_0000, 3'b000, 1}); // exactly -2^31
        q.push_back(vec_t'{32'h4F00_0000, c_pos_ovf,     3'b010, 1}); // +2^31
        q.push_back(vec_t'{32'hCF00_0001, 32'h8000_0000, 3'b010, 1}); // below -2^31
        q.push_back(vec_t'{32'h7FC0_0000, c_nan_res,     3'b100, 1}); // NaN
        q.push_back(vec_t'{32'h7F80_0000, c_pos_ovf,     3'b110, 1}); // +Inf
        q.push_back(vec_t'{32'hFF80_0000, 32'h8000_0000, 3'b110, 1}); // -Inf
        foreach (q[i]) begin
            convert(q[i].op, lat, res, flg);
            n_cmp++;
            if (res !== q[i].res) begin
                n_err++;
                $display("FAIL special_res[%h]: got %h want %h", q[i].op, res, q[i].res);
            end
            n_cmp++;
            if (flg !== q[i].flg) begin
                n_err++;
                $display("FAIL special_flg[%h]: got %b want %b", q[i].op, flg, q[i].flg);
            end
            n_cmp++;
            if (lat != q[i].lat) begin
                n_err++;
                $display("FAIL special_lat[%h]: got %0d want %0d", q[i].op, lat, q[i].lat);
            end
        end
    endtask

    task automatic test_underflow();
        vec_t q[$];
        int lat;
        logic [31:0] res;
        logic [2:0] flg;
        q.push_back(vec_t'{32'h3E80_0000, 32'h0, 3'b001, 1}); // 0.25
        q.push_back(vec_t'{32'h3F00_0000, 32'h0, 3'b001, 2}); // 0.5 ties to 0
        q.push_back(vec_t'{32'h0000_0000, 32'h0, 3'b000, 1}); // +0
        q.push_back(vec_t'{32'h8000_0000, 32'h0, 3'b000, 1}); // -0
        q.push_back(vec_t'{32'h0000_0001, 32'h0, 3'b001, 1}); // denormal
        foreach (q[i]) begin
            convert(q[i].op, lat, res, flg);
            n_cmp++;
            if (res !== q[i].res) begin
                n_err++;
                $display("FAIL unf_res[%h]: got %h want %h", q[i].op, res, q[i].res);
            end
            n_cmp++;
            if (flg !== q[i].flg) begin
                n_err++;
                $display("FAIL unf_flg[%h]: got %b want %b", q[i].op, flg, q[i].flg);
            end
            n_cmp++;
            if (lat != q[i].lat) begin
                n_err++;
                $display("FAIL unf_lat[%h]: got %0d want %0d", q[i].op, lat, q[i].lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int waited;
        logic [31:0] res;
        logic [2:0] flg;
        @(negedge clk);
        fp_in    = 32'h4020_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_err++;
            $display("FAIL bp_valid: out_valid got 0 want 1 within 20 cycles");
        end
        // Second operand offered while the first result is held.
        fp_in    = 32'h3F80_0000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({out_valid, in_ready, result, Exception, Overflow, Underflow} !== {2'b10, 32'h2, 3'b000}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b res=%h flg=%b want 1 0 00000002 000",
                         k, out_valid, in_ready, result, {Exception, Overflow, Underflow});
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_release: in_ready/out_valid got %b want 10", {in_ready, out_valid});
        end
        n_cmp++;
        if (result !== 32'h2) begin
            n_err++;
            $display("FAIL bp_stable: result got %h want 00000002", result);
        end
        convert(32'h4000_0000, lat, res, flg);
        n_cmp++;
        if ({res, flg} !== {32'h2, 3'b000} || lat != 3) begin
            n_err++;
            $display("FAIL bp_next: res=%h flg=%b lat=%0d want 00000002 000 3", res, flg, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        logic [2:0] flg;
        logic seen;
        convert(32'h3FC0_0000, lat, res, flg);  // leave a nonzero result registered
        @(negedge clk);
        fp_in    = 32'h4EFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, result} !== {2'b01, 32'h0}) begin
            n_err++;
            $display("FAIL rst_mid: ov=%b ir=%b res=%h want 0 1 00000000", out_valid, in_ready, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stale: out_valid got 1 want 0 after reset release");
        end
        convert(32'h3F80_0000, lat, res, flg);
        n_cmp++;
        if ({res, flg} !== {32'h1, 3'b000} || lat != 2) begin
            n_err++;
            $display("FAIL rst_recover: res=%h flg=%b lat=%0d want 00000001 000 2", res, flg, lat);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fp_in     = 32'h0;
        test_reset();
        test_rounding();
        test_special();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp32_to_int.md
# fp32_to_int

Sequential IEEE-754 single-precision to signed 32-bit integer converter. It is the inverse of the team's combinational integer-to-float encoder and sits on the same datapath, feeding integer consumers from float producers. It uses a valid/ready handshake on both sides and an iterative left-aligner, so area stays small. The output is rounded to nearest, ties to even, and carries Exception/Overflow/Underflow flags in the same style as the encoder.

## Interface
- SHIFT_STEP, 8: maximum left-shift distance per ALIGN cycle; legal values 1..31.
- clk  input  1  rising-edge clock; the block uses one clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  fp_in is valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- fp_in  input  32  IEEE-754 single-precision operand.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  32  two's-complement integer.
- Exception  output  1  operand was NaN or ±Inf.
- Overflow  output  1  rounded value is out of int32 range, or operand was ±Inf.
- Underflow  output  1  operand was nonzero (including denormals) but the rounded result is 0.

## Operation
- Unpack: s=fp_in[31], e=fp_in[30:23], f=fp_in[22:0], E=e-127.
- States: IDLE, ALIGN, ROUND, DONE.
- IDLE, on in_valid&in_ready, registers the operand and classifies it:
  - NaN or Inf (e=255): go to DONE.
  - Zero or denormal (e=0): go to DONE.
  - E≤-2: go to DONE with result 0 and Underflow=1.
  - E≥31: go to DONE, except exactly -2^31 (s=1, E=31, f=0), which gives 0x80000000 with no flags.
  - Otherwise: load the 58-bit accumulator. Integer field is acc[57:26], fraction field is acc[25:0]. Set acc[26]=1, acc[25:3]=f, rest 0.
  - Then: E>0 goes to ALIGN with remaining count rem=E; E=0 goes to ROUND; E=-1 shifts the accumulator right 1 and goes to ROUND.
- ALIGN: each cycle, shift acc left by min(rem, SHIFT_STEP) and decrement rem by the same amount. When rem reaches 0, go to ROUND.
- ROUND:
  - guard=acc[25], sticky=|acc[24:0], lsb=acc[26].
  - up = guard & (sticky | lsb).
  - mag = {1'b0, acc[57:26]} + up, 33 bits wide.
  - If s=0 and mag>0x7FFFFFFF, or s=1 and mag>0x80000000, set Overflow.
  - Otherwise result = s ? -mag : mag.
  - Underflow = (mag==0).
  - Go to DONE.
- DONE: hold out_valid and all outputs stable until out_ready; on out_ready go to IDLE.
- Special-case outputs (without the configuration macro):
  - NaN: result 0x80000000, Exception=1.
  - ±Inf: result 0x80000000, Exception=1, Overflow=1.
  - Finite overflow: result 0x80000000, Overflow=1.
  - Zero or denormal: result 0; Underflow=1 only when f≠0.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0, accumulator and rem cleared.
- Reset asserted mid-operation aborts the conversion immediately. The in-flight operand is discarded and no result is produced.
- Only one operand is in flight; there is no overlap. in_ready is low from the accept edge until the cycle after the DONE handshake.
- out_valid latency, counted in cycles after the accept edge:
  - Special cases and early exits: 1.
  - -1≤E≤0: 2.
  - E>0: 2+ceil(E/SHIFT_STEP). With the default SHIFT_STEP, the worst case is E=30, giving 6.
- If in_valid is high while in_ready is low, nothing happens; the operand is not sampled.
- Outputs are registered and change only on the DONE entry edge or on reset.

## Configuration
- FP2INT_SATURATE_EN defined:
  - Finite overflow and ±Inf saturate to 0x7FFFFFFF when s=0 and 0x80000000 when s=1.
  - NaN returns 0.
  - Flags are unchanged.
- FP2INT_SATURATE_EN undefined: all out-of-range operands and NaN return the integer-indefinite value 0x80000000, as listed under Operation.

## Test plan
- 0x3FC00000 (1.5) accepted → 2 cycles later result=0x00000002, all flags 0. This checks the tie case rounding up to even.
- 0x40200000 (2.5) → result=0x00000002 after 3 cycles; tie rounds to even, down. 0xBF400000 (-0.75) → result=0xFFFFFFFF, Underflow=0.
- 0x4EFFFFFF → result=0x7FFFFF80 after 6 cycles, with SHIFT_STEP=8. 0xCF000000 → 0x80000000 with no flags. 0x4F000000 → Overflow=1, result 0x80000000, or 0x7FFFFFFF when FP2INT_SATURATE_EN is defined.
- 0x7FC00000 → Exception=1 after 1 cycle. 0x3E800000 (0.25) → result 0, Underflow=1 after 1 cycle. 0x3F000000 (0.5) → 0, Underflow=1 after 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Outputs must stay stable, in_ready must stay 0, and a second in_valid must be ignored. Then assert out_ready: in_ready=1 on the next cycle.
- Reset: apply rst_n=0 during ALIGN for 0x4EFFFFFF. Immediately out_valid=0, in_ready=1, result=0, and no stale result appears after release.
